// File: rtl/mem_rw_tester.sv
// Manual access and March C- self-test front end for the on-chip RAM request port.
// Optional build macro MEMTEST_ERR_COUNT_EN: count mismatches over the whole test instead of stopping on the first.
module mem_rw_tester #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              ar,
    input  logic [DATA_W-1:0] uni_in,
    input  logic              a_btn,
    input  logic              rd_btn,
    input  logic              wr_btn,
    input  logic              it_btn,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_done,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done_led,
    output logic              pass_led,
    output logic              fail_led,
    output logic [DATA_W-1:0] disp_data
);

    typedef enum logic [2:0] {IDLE, MAN_RD, MAN_WR, T_WR, T_RD, T_STEP, T_END} state_t;

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

`ifdef MEMTEST_ERR_COUNT_EN
    localparam bit STOP_ON_FAIL = 1'b0;
    logic [DATA_W-1:0] r_err_cnt;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
    logic              r_err;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_mem_a, r_man_a, r_addr;
    logic [2:0]        r_elem;
    logic [DATA_W-1:0] r_mem_din, r_disp;
    logic              r_mem_rd, r_mem_wr, r_busy, r_done, r_pass, r_fail;

    logic              w_up, w_at_end, w_mismatch;
    logic [ADDR_W-1:0] w_addr_nxt, w_req_addr;
    logic [2:0]        w_elem_nxt, w_req_elem;
    logic [DATA_W-1:0] w_wdata;
    logic              w_issue_rd, w_issue_wr, w_issue_test;
    logic              w_latch_a, w_start, w_err_hit;

    // Write pattern of each element (M0 w0, M1 w1, M2 w0, M3 w1, M4 w0).
    function automatic logic [DATA_W-1:0] wr_pattern(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? '1 : '0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_pattern(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? '1 : '0;
    endfunction

    assign w_up       = !(r_elem == 3'd3 || r_elem == 3'd4);
    assign w_at_end   = w_up ? (r_addr == LAST_A) : (r_addr == '0);
    assign w_mismatch = (mem_dout != rd_pattern(r_elem));

    // Elements M3 and M4 start from the top; all others from address 0.
    always_comb begin
        w_elem_nxt = r_elem;
        w_addr_nxt = w_up ? r_addr + 1'b1 : r_addr - 1'b1;
        if (w_at_end) begin
            w_elem_nxt = r_elem + 3'd1;
            w_addr_nxt = (r_elem == 3'd2 || r_elem == 3'd3) ? LAST_A : '0;
        end
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) r_state <= IDLE;
        else    r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue_rd   = 1'b0;
        w_issue_wr   = 1'b0;
        w_issue_test = 1'b0;
        w_req_addr   = r_addr;
        w_req_elem   = r_elem;
        w_wdata      = uni_in;
        w_latch_a    = 1'b0;
        w_start      = 1'b0;
        w_err_hit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (it_btn) begin
                    w_start      = 1'b1;
                    w_issue_wr   = 1'b1;
                    w_issue_test = 1'b1;
                    w_req_addr   = '0;
                    w_req_elem   = 3'd0;
                    w_wdata      = wr_pattern(3'd0);
                    w_state_nxt  = T_WR;
                end else if (wr_btn) begin
                    w_issue_wr  = 1'b1;
                    w_state_nxt = MAN_WR;
                end else if (rd_btn) begin
                    w_issue_rd  = 1'b1;
                    w_state_nxt = MAN_RD;
                end else if (a_btn) begin
                    w_latch_a = 1'b1;
                end
            end
            MAN_RD, MAN_WR: begin
                if (mem_done) w_state_nxt = IDLE;
            end
            T_WR: begin
                if (mem_done) w_state_nxt = T_STEP;
            end
            T_RD: begin
                if (mem_done) begin
                    w_err_hit = w_mismatch;
                    if (STOP_ON_FAIL && w_mismatch) begin
                        w_state_nxt = T_END;
                    end else if (r_elem == 3'd5) begin
                        w_state_nxt = T_STEP;
                    end else begin
                        w_issue_wr   = 1'b1;
                        w_issue_test = 1'b1;
                        w_wdata      = wr_pattern(r_elem);
                        w_state_nxt  = T_WR;
                    end
                end
            end
            T_STEP: begin
                if (w_at_end && r_elem == 3'd5) begin
                    w_state_nxt = T_END;
                end else begin
                    w_issue_test = 1'b1;
                    w_req_addr   = w_addr_nxt;
                    w_req_elem   = w_elem_nxt;
                    if (w_elem_nxt == 3'd0) begin
                        w_issue_wr  = 1'b1;
                        w_wdata     = wr_pattern(3'd0);
                        w_state_nxt = T_WR;
                    end else begin
                        w_issue_rd  = 1'b1;
                        w_state_nxt = T_RD;
                    end
                end
            end
            T_END:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_mem_a   <= '0;
            r_man_a   <= '0;
            r_addr    <= '0;
            r_elem    <= '0;
            r_mem_din <= '0;
            r_disp    <= '0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
`ifdef MEMTEST_ERR_COUNT_EN
            r_err_cnt <= '0;
`else
            r_err     <= 1'b0;
`endif
        end else begin
            // A request holds until mem_done and drops on the following edge.
            if (w_issue_rd)    r_mem_rd <= 1'b1;
            else if (mem_done) r_mem_rd <= 1'b0;
            if (w_issue_wr) begin
                r_mem_wr  <= 1'b1;
                r_mem_din <= w_wdata;
            end else if (mem_done) begin
                r_mem_wr <= 1'b0;
            end
            if (w_issue_rd || w_issue_wr) r_busy <= 1'b1;
            if (w_issue_test) begin
                r_addr  <= w_req_addr;
                r_elem  <= w_req_elem;
                r_mem_a <= w_req_addr;
            end
            if (w_latch_a) begin
                r_man_a <= uni_in[ADDR_W-1:0];
                r_mem_a <= uni_in[ADDR_W-1:0];
                r_disp  <= DATA_W'(uni_in[ADDR_W-1:0]);
                r_done  <= 1'b0;
            end
            if (w_start) begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
                r_fail <= 1'b0;
`ifdef MEMTEST_ERR_COUNT_EN
                r_err_cnt <= '0;
`else
                r_err     <= 1'b0;
`endif
            end
            if (mem_done && r_state == MAN_WR) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_disp <= r_mem_din;
            end
            if (mem_done && r_state == MAN_RD) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_disp <= mem_dout;
            end
`ifdef MEMTEST_ERR_COUNT_EN
            if (w_err_hit && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
`else
            if (w_err_hit) r_err <= 1'b1;
`endif
            if (r_state == T_END) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_mem_a <= r_man_a;
`ifdef MEMTEST_ERR_COUNT_EN
                r_fail  <= (r_err_cnt != '0);
                r_pass  <= (r_err_cnt == '0);
                r_disp  <= r_err_cnt;
`else
                r_fail  <= r_err;
                r_pass  <= !r_err;
                r_disp  <= r_err ? DATA_W'(r_addr) : '0;
`endif
            end
        end
    end

    assign mem_a     = r_mem_a;
    assign mem_din   = r_mem_din;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign busy      = r_busy;
    assign done_led  = r_done;
    assign pass_led  = r_pass;
    assign fail_led  = r_fail;
    assign disp_data = r_disp;

endmodule

// File: tb/tb_mem_rw_tester.sv
// Directed bench for mem_rw_tester with a 2-cycle RAM model, optional stuck-at fault at address 9.
module tb_mem_rw_tester;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic [15:0] uni_in = '0;
    logic        a_btn = 1'b0, rd_btn = 1'b0, wr_btn = 1'b0, it_btn = 1'b0;
    logic [15:0] mem_dout = '0;
    logic        mem_done;
    logic [3:0]  mem_a;
    logic [15:0] mem_din, disp_data;
    logic        mem_rd, mem_wr, busy, done_led, pass_led, fail_led;

    logic        ram_done = 1'b0;
    logic        inj_done = 1'b0;
    logic        stuck = 1'b0;
    assign mem_done = ram_done | inj_done;

    mem_rw_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .ar(ar), .uni_in(uni_in), .a_btn(a_btn), .rd_btn(rd_btn),
        .wr_btn(wr_btn), .it_btn(it_btn), .mem_dout(mem_dout), .mem_done(mem_done),
        .mem_a(mem_a), .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .busy(busy), .done_led(done_led), .pass_led(pass_led), .fail_led(fail_led),
        .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:15];
    logic        log_wr [0:1023];
    logic [3:0]  log_a  [0:1023];
    logic [15:0] log_d  [0:1023];
    int log_n = 0, wr_cnt = 0, rd_cnt = 0, ram_cnt = 0, excl_viol = 0;

    // RAM model: completes a request two cycles after it is first seen.
    always @(negedge clk) begin
        if (mem_rd && mem_wr) excl_viol++;
        if (ar) begin
            ram_done = 1'b0;
            ram_cnt  = 0;
        end else if (ram_done) begin
            ram_done = 1'b0;
            ram_cnt  = 0;
        end else if (mem_rd || mem_wr) begin
            if (ram_cnt == 1) begin
                ram_done = 1'b1;
                ram_cnt  = 0;
                if (mem_wr) begin
                    ram[mem_a] = mem_din | ((stuck && mem_a == 4'd9) ? 16'h0008 : 16'h0000);
                    wr_cnt++;
                end else begin
                    mem_dout = ram[mem_a];
                    rd_cnt++;
                end
                if (log_n < 1024) begin
                    log_wr[log_n] = mem_wr;
                    log_a[log_n]  = mem_a;
                    log_d[log_n]  = mem_wr ? mem_din : mem_dout;
                end
                log_n++;
            end else begin
                ram_cnt++;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = a_btn, 1 = rd_btn, 2 = wr_btn, 3 = it_btn
    task automatic pulse_btn(input int b);
        a_btn  = (b == 0);
        rd_btn = (b == 1);
        wr_btn = (b == 2);
        it_btn = (b == 3);
        tick();
        a_btn = 1'b0; rd_btn = 1'b0; wr_btn = 1'b0; it_btn = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, busy=1 expected 0", name);
        end
    endtask

    int k_exp, bad_order;
    task automatic exp_acc(input logic wr, input logic [3:0] a, input logic [15:0] d);
        if (k_exp >= log_n || log_wr[k_exp] !== wr || log_a[k_exp] !== a || log_d[k_exp] !== d)
            bad_order++;
        k_exp++;
    endtask

    typedef struct {
        int          op;
        logic [15:0] din;
        logic [3:0]  ea;
        logic [15:0] ed;
        logic        edone;
    } vec_t;
    vec_t vt [0:8];

    initial begin
        int wr0, rd0, base;
        vt[0] = '{0, 16'h0005, 4'd5, 16'h0005, 1'b0};
        vt[1] = '{2, 16'hBEEF, 4'd5, 16'hBEEF, 1'b1};
        vt[2] = '{1, 16'h1234, 4'd5, 16'hBEEF, 1'b1};
        vt[3] = '{0, 16'hFFF9, 4'd9, 16'h0009, 1'b0};
        vt[4] = '{2, 16'h1234, 4'd9, 16'h1234, 1'b1};
        vt[5] = '{0, 16'h0005, 4'd5, 16'h0005, 1'b0};
        vt[6] = '{1, 16'h0000, 4'd5, 16'hBEEF, 1'b1};
        vt[7] = '{0, 16'h0009, 4'd9, 16'h0009, 1'b0};
        vt[8] = '{1, 16'h0000, 4'd9, 16'h1234, 1'b1};

        tick();
        tick();
        chk("reset_outputs", {mem_a, mem_din, mem_rd, mem_wr, busy, done_led, pass_led, fail_led, disp_data}, '0);
        ar = 1'b0;
        tick();

        // Reset mid-write
        uni_in = 16'h5555;
        pulse_btn(2);
        chk("midwr_mem_wr", mem_wr, 1'b1);
        #2 ar = 1'b1;
        #1;
        chk("midwr_async_drop", {mem_rd, mem_wr}, 2'b00);
        chk("midwr_all_zero", {mem_a, mem_din, mem_rd, mem_wr, busy, done_led, pass_led, fail_led, disp_data}, '0);
        tick();
        ar = 1'b0;
        tick();
        chk("midwr_idle_busy", busy, 1'b0);

        // Manual access table
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 9; i++) begin
            uni_in = vt[i].din;
            pulse_btn(vt[i].op);
            if (vt[i].op != 0) wait_idle(50, "manual");
            chk($sformatf("vec%0d_mem_a", i), mem_a, vt[i].ea);
            chk($sformatf("vec%0d_disp", i), disp_data, vt[i].ed);
            chk($sformatf("vec%0d_done", i), done_led, vt[i].edone);
        end
        chk("manual_writes", wr_cnt - wr0, 2);
        chk("manual_reads", rd_cnt - rd0, 3);

        // wr_btn + rd_btn together, then rd_btn while busy
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        uni_in = 16'h00AA;
        wr_btn = 1'b1;
        rd_btn = 1'b1;
        tick();
        wr_btn = 1'b0;
        rd_btn = 1'b0;
        chk("prio_mem_wr", {mem_rd, mem_wr}, 2'b01);
        rd_btn = 1'b1;
        tick();
        rd_btn = 1'b0;
        wait_idle(50, "prio");
        tick();
        tick();
        chk("prio_writes", wr_cnt - wr0, 1);
        chk("prio_reads", rd_cnt - rd0, 0);
        chk("prio_disp", disp_data, 16'h00AA);

        // Spurious mem_done in IDLE
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        tick();
        chk("spur_state", {busy, mem_rd, mem_wr, done_led, mem_a}, {1'b0, 1'b0, 1'b0, 1'b1, 4'd9});
        chk("spur_disp", disp_data, 16'h00AA);

        // March C- on a good RAM
        stuck = 1'b0;
        base = log_n;
        pulse_btn(3);
        chk("march_start", {busy, done_led, pass_led, fail_led}, 4'b1000);
        wait_idle(3000, "march");
        chk("march_leds", {busy, done_led, pass_led, fail_led}, 4'b0110);
        chk("march_disp", disp_data, 16'h0000);
        chk("march_mem_a_restored", mem_a, 4'd9);
        chk("march_accesses", log_n - base, 160);
        k_exp = base;
        bad_order = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < DEPTH; j++) begin
                logic [3:0] a;
                a = (e == 3 || e == 4) ? 4'(15 - j) : 4'(j);
                if (e == 0) begin
                    exp_acc(1'b1, a, 16'h0000);
                end else begin
                    exp_acc(1'b0, a, (e == 2 || e == 4) ? 16'hFFFF : 16'h0000);
                    if (e != 5) exp_acc(1'b1, a, (e == 1 || e == 3) ? 16'hFFFF : 16'h0000);
                end
            end
        end
        chk("march_order_errors", bad_order, 0);

        // Stuck-at-1 on bit 3 of address 9
        stuck = 1'b1;
        base = log_n;
        pulse_btn(3);
        wait_idle(3000, "stuck");
        chk("stuck_leds", {busy, done_led, pass_led, fail_led}, 4'b0101);
`ifdef MEMTEST_ERR_COUNT_EN
        chk("stuck_disp", disp_data, 16'h0003);
        chk("stuck_accesses", log_n - base, 160);
`else
        chk("stuck_disp", disp_data, 16'h0009);
        chk("stuck_accesses", log_n - base, 35);
`endif
        chk("stuck_mem_a_restored", mem_a, 4'd9);
        chk("rd_wr_exclusive", excl_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
